// File: rtl/enc_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package enc_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/enc_rr_arbiter_rr_pick.sv
// Rotating-priority search: the first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import enc_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pick_id = '0;
        pick    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = idx;
            end
        end
        if (found) begin
            pick = NUM_REQ'(1) << pick_id;
        end
    end

endmodule

// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter for four requesters with a bounded hold time and a one-cycle
// bubble between owners.
//
//   state | meaning
//   IDLE  | no grant; arbitrate when enb=1 and a request is present
//   GRANT | one requester owns the grant; hold counter running
//   GAP   | single bubble cycle after a grant ends; may re-arbitrate next edge
module enc_rr_arbiter
    import enc_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               gnt_vld_d;
    logic               timeout_d;

    logic [NUM_REQ-1:0] pick;
    logic [ID_W-1:0]    pick_id;
    logic               released;
    logic               hit_lim;

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (pick),
        .pick_id (pick_id)
    );

    // An owner-side release wins over the limit, so a coincident limit is not a timeout.
    assign released = rel || !req[gnt_id_q_sel()];
    assign hit_lim  = (cnt_q == HOLD_LIM);

    function automatic logic [ID_W-1:0] gnt_id_q_sel();
        return gnt_id;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            gnt_vld <= gnt_vld_d;
            timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: state_d = (enb && (req != '0)) ? GRANT : IDLE;
            GRANT:     if (released || hit_lim) state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = '0;
        gnt_d     = '0;
        gnt_id_d  = '0;
        gnt_vld_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (state_d == GRANT) begin
                    gnt_d     = pick;
                    gnt_id_d  = pick_id;
                    gnt_vld_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                end
            end
            GRANT: begin
                if (state_d == GAP) begin
                    ptr_d     = gnt_id + ID_W'(1);
                    timeout_d = !released;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    gnt_d     = gnt;
                    gnt_id_d  = gnt_id;
                    gnt_vld_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Self-checking bench for enc_rr_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_enc_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       rel = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model: current owner (-1 = none), cycles held, rotating start, pulse
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    always #5 clk = ~clk;

    enc_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    function automatic logic [7:0] obs();
        return {gnt, gnt_id, gnt_vld, timeout};
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] g  = 4'b0000;
        logic [1:0] id = 2'd0;
        if (m_owner >= 0) begin
            g  = 4'(1) << m_owner;
            id = 2'(m_owner);
        end
        return {g, id, (m_owner >= 0), m_to};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (rel || !req[m_owner] || m_held == HOLD) begin
                m_to    = !(rel || !req[m_owner]);
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (enb && req != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            m_held = 1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enb = 1'b0;
        req = 4'b0000;
        rel = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if (obs() !== 8'b0) begin
            n_fails++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), 8'b0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if (obs() !== exp_vec()) begin
            n_fails++;
            $display("FAIL reset_idle: got %b expected %b", obs(), exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        enb = 1'b1;
        req = 4'b0100;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_vld !== 1'b1) begin
            n_fails++;
            $display("FAIL single_grant: got gnt=%b id=%0d vld=%b expected gnt=0100 id=2 vld=1", gnt, gnt_id, gnt_vld);
        end
        rel = 1'b1;
        step();
        rel = 1'b0;
        n_checks++;
        if (obs() !== exp_vec()) begin
            n_fails++;
            $display("FAIL single_release: got %b expected %b", obs(), exp_vec());
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        enb = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            want = 4'(1) << (i % 4);
            n_checks++;
            if (gnt !== want || obs() !== exp_vec()) begin
                n_fails++;
                $display("FAIL rr_owner_%0d: got gnt=%b vec=%b expected gnt=%b vec=%b", i, gnt, obs(), want, exp_vec());
            end
            step();
            step();
            rel = 1'b1;
            step();
            rel = 1'b0;
            n_checks++;
            if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
                n_fails++;
                $display("FAIL rr_gap_%0d: got gnt=%b vld=%b to=%b expected all 0", i, gnt, gnt_vld, timeout);
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        do_reset();
        enb = 1'b1;
        req = 4'b0001;
        step();
        for (int i = 0; i < 10 && gnt == 4'b0001; i++) begin
            hi++;
            step();
        end
        n_checks++;
        if (hi != HOLD) begin
            n_fails++;
            $display("FAIL timeout_hold_len: got %0d cycles expected %0d", hi, HOLD);
        end
        n_checks++;
        if (timeout !== 1'b1 || gnt !== 4'b0000 || obs() !== exp_vec()) begin
            n_fails++;
            $display("FAIL timeout_pulse: got to=%b gnt=%b expected to=1 gnt=0000", timeout, gnt);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_regrant: got gnt=%b to=%b expected gnt=0001 to=0", gnt, timeout);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        enb = 1'b1;
        req = 4'b0001;
        repeat (HOLD) step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        n_checks++;
        if (timeout !== 1'b0 || gnt !== 4'b0000) begin
            n_fails++;
            $display("FAIL coincide_rel: got to=%b gnt=%b expected to=0 gnt=0000", timeout, gnt);
        end
        repeat (HOLD) step();
        req = 4'b0000;
        step();
        n_checks++;
        if (timeout !== 1'b0 || gnt !== 4'b0000 || obs() !== exp_vec()) begin
            n_fails++;
            $display("FAIL coincide_drop: got to=%b gnt=%b expected to=0 gnt=0000", timeout, gnt);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        enb = 1'b1;
        req = 4'b1000;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fails++;
            $display("FAIL wrap_owner3: got gnt=%b id=%0d expected gnt=1000 id=3", gnt, gnt_id);
        end
        req = 4'b0110;
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_fails++;
            $display("FAIL wrap_skip: got gnt=%b id=%0d expected gnt=0010 id=1", gnt, gnt_id);
        end
    endtask

    task automatic test_enable();
        do_reset();
        enb = 1'b0;
        req = 4'b1010;
        repeat (3) begin
            step();
            n_checks++;
            if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
                n_fails++;
                $display("FAIL enable_off: got gnt=%b vld=%b expected 0000/0", gnt, gnt_vld);
            end
        end
        enb = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fails++;
            $display("FAIL enable_grant: got gnt=%b expected 0010", gnt);
        end
        enb = 1'b0;
        step();
        step();
        n_checks++;
        if (gnt !== 4'b0010 || gnt_vld !== 1'b1) begin
            n_fails++;
            $display("FAIL enable_hold: got gnt=%b vld=%b expected 0010/1", gnt, gnt_vld);
        end
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || obs() !== exp_vec()) begin
            n_fails++;
            $display("FAIL enable_idle: got %b expected %b", obs(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enb = 1'b1;
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fails++;
            $display("FAIL rstmid_grant: got gnt=%b expected 0010", gnt);
        end
        req = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs() !== 8'b0) begin
            n_fails++;
            $display("FAIL rstmid_async: got %b expected %b", obs(), 8'b0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_fails++;
            $display("FAIL rstmid_first: got gnt=%b id=%0d expected gnt=0001 id=0", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            enb = ($urandom_range(0, 3) != 0);
            req = 4'($urandom);
            rel = ($urandom_range(0, 4) == 0);
            step();
            n_checks++;
            if (obs() !== exp_vec() || $countones(gnt) > 1) begin
                n_fails++;
                $display("FAIL random_cycle_%0d: got %b expected %b", i, obs(), exp_vec());
            end
        end
        rel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_coincide();
        test_wrap_skip();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/enc_rr_arbiter.md
ENC_RR_ARBITER -- requirements
Module: enc_rr_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 15, meaning the maximum number of consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port enb, input, 1 bit: arbitration enable; when low, no new grant is issued.
REQ-005 The block SHALL have port req, input, 4 bits: one request line per requester, bit n belonging to requester n.
REQ-006 The block SHALL have port rel, input, 1 bit: release strobe from the current owner.
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-008 The block SHALL have port gnt_id, output, 2 bits: binary index of the owner, valid only while gnt_vld is high, and 0 otherwise.
REQ-009 The block SHALL have port gnt_vld, output, 1 bit: high while any grant is held.
REQ-010 The block SHALL have port timeout, output, 1 bit: a single-cycle pulse when a grant is revoked by HOLD_MAX.

Function
REQ-011 The controller SHALL implement three states: IDLE, GRANT and GAP.
REQ-012 In IDLE or GAP, with enb=1 and req!=0, the controller SHALL go to GRANT next cycle.
REQ-013 The winner in REQ-012 SHALL be the first set req bit searching ptr, ptr+1, ... modulo 4.
REQ-014 Grant latency SHALL be 1 cycle: gnt, gnt_id and gnt_vld update on the edge after the qualifying req or enb sample.
REQ-015 In IDLE or GAP, with enb=0 or req=0, the controller SHALL go to IDLE with gnt=0.
REQ-016 A hold counter SHALL load 1 on entry to GRANT and increment each further GRANT cycle; its width SHALL be clog2(HOLD_MAX+1).
REQ-017 GRANT SHALL exit to GAP when any one of the following holds: rel=1; req[owner]=0; the counter equals HOLD_MAX.
REQ-018 timeout SHALL pulse high for one cycle, coincident with GAP entry, only when the exit cause is the counter reaching HOLD_MAX.
REQ-019 When rel or a req drop coincides with the counter reaching HOLD_MAX, the exit SHALL count as a release and timeout SHALL stay 0.
REQ-020 On every GRANT-to-GAP transition, ptr SHALL load (owner+1) mod 4, wrapping from 3 to 0.
REQ-021 GAP SHALL last exactly one cycle with gnt=0, giving a one-cycle bubble between owners.
REQ-022 Deasserting enb during GRANT SHALL NOT revoke the current grant.
REQ-023 rel SHALL be ignored in IDLE and GAP.
REQ-024 Requests from non-owners SHALL NOT affect the state while in GRANT.
REQ-025 gnt SHALL always be one-hot or zero, and SHALL equal the decode of gnt_id when gnt_vld=1.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, ptr=0, counter=0, gnt=0, gnt_id=0, gnt_vld=0 and timeout=0, including in the middle of a grant.
REQ-027 After rst is released, the first arbitration SHALL occur on the first rising edge with enb=1 and req!=0.

Structure
REQ-028 A shared package enc_arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP) and the constants NUM_REQ=4 and ID_W=2.
REQ-029 The rotating priority search SHALL be one combinational sub-module, rr_pick, with inputs req[3:0] and ptr[1:0] and outputs a one-hot pick and its binary index.
REQ-030 The FSM, ptr, counter and output registers SHALL reside in enc_rr_arbiter.

Verification
REQ-031 Scenario single request: reset, then enb=1, req=4'b0100 -> next cycle gnt=0100, gnt_id=2, gnt_vld=1.
REQ-032 Scenario round-robin: req=4'b1111 held, each owner pulses rel 3 cycles after its grant -> grants follow 0,1,2,3,0, each followed by one gnt=0 GAP cycle.
REQ-033 Scenario timeout: HOLD_MAX=4, req=4'b0001 held with no rel -> gnt high exactly 4 cycles; timeout=1 in the GAP cycle; the requester is then re-granted because it is the only requester.
REQ-034 Scenario wrap and skip: the owner is 3 and releases with req=4'b0110 -> the next owner is 1, because ptr wraps to 0 and bit 0 is clear.
REQ-035 Scenario enable: enb=0 with req=4'b1010 -> gnt stays 0; enb dropped mid-grant -> the grant holds until rel.
REQ-036 Scenario reset mid-grant: assert rst while gnt=0010 -> all outputs are 0 immediately; after release with req=4'b1111 -> the first grant goes to 0.
